// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } hazard_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational forwarding select for one EX operand; MEM result wins over WB.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
      fwd_sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, multi-cycle EX
// sequencing with timeout abort, operand forwarding and a stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_mc_start,
  input  logic             mc_done,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             ex_hold,
  output logic             exmem_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output hazard_state_e    dbg_state
);

  localparam int TW = $clog2(MC_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MC_TIMEOUT - 1);

  hazard_state_e    state_q, state_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             mc_timeout_q, mc_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;

  fwd_unit u_fwd_a (
    .ex_rs         (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_sel       (fwd_a)
  );

  fwd_unit u_fwd_b (
    .ex_rs         (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_sel       (fwd_b)
  );

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    ex_hold      = 1'b0;
    exmem_bubble = 1'b0;
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    mc_timeout_d = mc_timeout_q;
    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
        end else if (ex_mc_start && !mc_done) begin
          pc_stall     = 1'b1;
          ifid_stall   = 1'b1;
          ex_hold      = 1'b1;
          exmem_bubble = 1'b1;
          state_d      = MC_BUSY;
          // The counter tracks stalled cycles of the op, and the start cycle is the first.
          tmo_cnt_d    = TW'(1);
        end
      end
      MC_BUSY: begin
        if (mc_done) begin
          state_d = RUN;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d      = RUN;
          mc_timeout_d = 1'b1;
        end else begin
          pc_stall     = 1'b1;
          ifid_stall   = 1'b1;
          ex_hold      = 1'b1;
          exmem_bubble = 1'b1;
          tmo_cnt_d    = tmo_cnt_q + TW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      tmo_cnt_q    <= '0;
      mc_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      mc_timeout_q <= mc_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign mc_timeout   = mc_timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl with a short timeout and narrow counter.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int MC_TIMEOUT = 8;
  localparam int CNT_W      = 4;
  localparam int W          = 1 + CNT_W + 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_mc_start, mc_done;
  logic mem_reg_write, wb_reg_write;
  logic pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold, exmem_bubble, mc_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cycles;
  hazard_state_e dbg_state;

  logic [W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_sc = '0;
  int checks = 0;
  int failures = 0;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110100;
  localparam logic [5:0] C_BR   = 6'b001100;
  localparam logic [5:0] C_MC   = 6'b110011;

  hazard_ctrl #(.MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .ex_hold(ex_hold), .exmem_bubble(exmem_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mc_timeout(mc_timeout),
    .stall_cycles(stall_cycles), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_branch_taken = 0;
    ex_mc_start = 0; mc_done = 0; mem_reg_write = 0; wb_reg_write = 0;
  endtask

  task automatic push_exp(input logic [5:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                          input logic to, input hazard_state_e st);
    exp_q.push_back({st, exp_sc, ctl, fa, fb, to});
  endtask

  task automatic compare(input string tag);
    logic [W-1:0] got, exp;
    got = {dbg_state, stall_cycles, pc_stall, ifid_stall, ifid_flush, idex_bubble,
           ex_hold, exmem_bubble, fwd_a, fwd_b, mc_timeout};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, got);
    end else begin
      exp = exp_q.pop_front();
      assert (got === exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
      if (exp[10] && exp_sc != {CNT_W{1'b1}}) exp_sc++;
    end
  endtask

  // Called just after a rising edge; checks at the falling edge, returns after the next rise.
  task automatic cyc(input string tag, input logic [5:0] ctl, input logic [1:0] fa,
                     input logic [1:0] fb, input logic to, input hazard_state_e st);
    push_exp(ctl, fa, fb, to, st);
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    cyc("reset", C_NONE, 2'b00, 2'b00, 1'b0, RUN);
    rst = 1'b0;

    ex_rs1 = 5; ex_rs2 = 5; mem_rd = 5; wb_rd = 5; mem_reg_write = 1; wb_reg_write = 1;
    cyc("fwd_mem", C_NONE, 2'b10, 2'b10, 1'b0, RUN);
    mem_reg_write = 0;
    cyc("fwd_wb", C_NONE, 2'b01, 2'b01, 1'b0, RUN);
    mem_reg_write = 1; ex_rs1 = 0; ex_rs2 = 0; mem_rd = 0; wb_rd = 0;
    cyc("fwd_x0", C_NONE, 2'b00, 2'b00, 1'b0, RUN);
    ex_rs1 = 4; ex_rs2 = 3; mem_rd = 4; wb_rd = 3;
    cyc("fwd_split", C_NONE, 2'b10, 2'b01, 1'b0, RUN);
    wb_rd = 4;
    cyc("fwd_mem_beats_wb", C_NONE, 2'b10, 2'b00, 1'b0, RUN);

    idle(); ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
    cyc("load_use_rs2", C_LU, 2'b00, 2'b00, 1'b0, RUN);
    idle();
    cyc("load_use_release", C_NONE, 2'b00, 2'b00, 1'b0, RUN);
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 0;
    cyc("load_use_unused", C_NONE, 2'b00, 2'b00, 1'b0, RUN);
    idle(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    cyc("load_use_x0", C_NONE, 2'b00, 2'b00, 1'b0, RUN);
    ex_rd = 7; id_rs1 = 7;
    cyc("load_use_rs1", C_LU, 2'b00, 2'b00, 1'b0, RUN);
    ex_branch_taken = 1;
    cyc("branch_over_lu", C_BR, 2'b00, 2'b00, 1'b0, RUN);

    idle(); ex_mc_start = 1;
    cyc("mc_start", C_MC, 2'b00, 2'b00, 1'b0, RUN);
    idle();
    cyc("mc_busy1", C_MC, 2'b00, 2'b00, 1'b0, MC_BUSY);
    ex_branch_taken = 1; ex_mc_start = 1; ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1;
    cyc("mc_busy_ignore", C_MC, 2'b00, 2'b00, 1'b0, MC_BUSY);
    idle();
    cyc("mc_busy3", C_MC, 2'b00, 2'b00, 1'b0, MC_BUSY);
    cyc("mc_busy4", C_MC, 2'b00, 2'b00, 1'b0, MC_BUSY);
    mc_done = 1;
    cyc("mc_done", C_NONE, 2'b00, 2'b00, 1'b0, MC_BUSY);
    idle();
    cyc("mc_back_run", C_NONE, 2'b00, 2'b00, 1'b0, RUN);
    ex_mc_start = 1; mc_done = 1;
    cyc("mc_single", C_NONE, 2'b00, 2'b00, 1'b0, RUN);
    idle();
    cyc("mc_single_after", C_NONE, 2'b00, 2'b00, 1'b0, RUN);

    ex_mc_start = 1;
    cyc("tmo_start", C_MC, 2'b00, 2'b00, 1'b0, RUN);
    idle();
    for (int i = 0; i < MC_TIMEOUT - 2; i++) begin
      cyc($sformatf("tmo_busy%0d", i + 1), C_MC, 2'b00, 2'b00, 1'b0, MC_BUSY);
    end
    cyc("tmo_release", C_NONE, 2'b00, 2'b00, 1'b0, MC_BUSY);
    cyc("tmo_flag", C_NONE, 2'b00, 2'b00, 1'b1, RUN);
    cyc("tmo_sticky", C_NONE, 2'b00, 2'b00, 1'b1, RUN);

    ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_uses_rs2 = 1;
    cyc("sat_reach", C_LU, 2'b00, 2'b00, 1'b1, RUN);
    cyc("sat_hold", C_LU, 2'b00, 2'b00, 1'b1, RUN);
    idle();
    cyc("sat_value", C_NONE, 2'b00, 2'b00, 1'b1, RUN);

    rst = 1'b1; exp_sc = '0;
    cyc("rst_clears_tmo", C_NONE, 2'b00, 2'b00, 1'b0, RUN);
    rst = 1'b0;

    ex_mc_start = 1;
    cyc("rst_mc_start", C_MC, 2'b00, 2'b00, 1'b0, RUN);
    idle();
    cyc("rst_mc_busy1", C_MC, 2'b00, 2'b00, 1'b0, MC_BUSY);
    cyc("rst_mc_busy2", C_MC, 2'b00, 2'b00, 1'b0, MC_BUSY);
    #2 rst = 1'b1; exp_sc = '0;
    #1;
    push_exp(C_NONE, 2'b00, 2'b00, 1'b0, RUN);
    compare("rst_mid_busy");
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("rst_after", C_NONE, 2'b00, 2'b00, 1'b0, RUN);
    ex_mc_start = 1; mc_done = 1;
    cyc("rst_then_single", C_NONE, 2'b00, 2'b00, 1'b0, RUN);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central pipeline hazard controller for the 5-stage RV32I core. Each cycle it decides stalls, bubbles, flushes and forwarding selects for IF/ID, ID/EX and EX/MEM. It also sequences multi-cycle EX operations through a small FSM with a timeout. It keeps a saturating stall-cycle counter for performance visibility.

## Interface
Parameters:
- MC_TIMEOUT, 64: maximum MC_BUSY cycles before forced abort (≥2).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction actually reads that source.
- ex_rs1, ex_rs2  in  5  source registers of the instruction in EX.
- ex_rd  in  5  destination register in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- ex_mc_start  in  1  a multi-cycle op (div/rem) entered EX this cycle.
- mc_done  in  1  the multi-cycle unit result is valid this cycle.
- mem_rd, wb_rd  in  5  destinations in MEM and WB.
- mem_reg_write, wb_reg_write  in  1  MEM / WB will write rd.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  drives the ID/EX stall (zeroing) input.
- ex_hold  out  1  freeze EX operands and the multi-cycle unit inputs.
- exmem_bubble  out  1  insert NOP into EX/MEM.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM.
- mc_timeout  out  1  sticky error; set on timeout abort.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1.

## Operation
- Forwarding is purely combinational and independent of state.
  - fwd_a = 10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1.
  - Otherwise fwd_a = 01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs1.
  - Otherwise fwd_a = 00.
  - fwd_b uses the same rules on ex_rs2. MEM beats WB.
- load_use = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- FSM states: RUN, MC_BUSY.
- RUN, priority order (highest first):
  1. ex_branch_taken: ifid_flush=1, idex_bubble=1, no stalls. Load-use is ignored because the ID instruction is being squashed.
  2. load_use: pc_stall=1, ifid_stall=1, idex_bubble=1.
  3. ex_mc_start: pc_stall=1, ifid_stall=1, ex_hold=1, exmem_bubble=1; go to MC_BUSY next cycle; clear the timeout counter. If mc_done is also high in the same cycle, the op is single-cycle: none of these outputs assert and the FSM stays in RUN.
- MC_BUSY:
  - While mc_done=0: pc_stall, ifid_stall, ex_hold and exmem_bubble are all 1; the counter increments.
  - On mc_done=1: all outputs are 0 this cycle, so the result flows to EX/MEM; return to RUN.
  - Counter reaching MC_TIMEOUT-1 without mc_done: that cycle acts as release (outputs 0); set mc_timeout; return to RUN.
  - ex_branch_taken, load_use and ex_mc_start are ignored in MC_BUSY.
- stall_cycles increments on every cycle with pc_stall=1 and saturates at all-ones.
- mc_timeout clears only on rst.

## Timing
- Reset values: state RUN, timeout counter 0, stall_cycles 0, mc_timeout 0.
- Every combinational output follows from reset state and inputs; with idle inputs all outputs are 0.
- All control outputs are combinational from the current state and inputs, so they take effect at the next clock edge.
- Load-use costs exactly 1 bubble cycle; the stall drops the next cycle because the load has moved to MEM.
- A multi-cycle op occupying N cycles (mc_done in cycle N after start) stalls the front end for N-1 cycles.
- An abort holds for exactly MC_TIMEOUT-1 stalled cycles plus one release cycle.
- rst asserted mid-MC_BUSY returns the FSM to RUN immediately (asynchronous) and drops all holds.

## Structure
- Package hazard_pkg holds:
  - the state enum (RUN, MC_BUSY);
  - fwd select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One natural sub-module, fwd_unit: the combinational forwarding comparator, instantiated once per operand.

## Test plan
- Forwarding: ex_rs1=5, mem_rd=5, wb_rd=5, both writes=1 -> fwd_a=10. Then mem_reg_write=0 -> fwd_a=01. Then ex_rs1=0 with rd=0 -> fwd_a=00.
- Load-use: ex_mem_read=1, ex_rd=7, id_rs2=7, id_uses_rs2=1 -> pc_stall, ifid_stall and idex_bubble high for exactly 1 cycle; stall_cycles=1. The same hazard with id_uses_rs2=0 -> no stall.
- Branch over load-use: ex_branch_taken=1 together with a load-use match -> ifid_flush=1, idex_bubble=1, pc_stall=0.
- Multi-cycle: ex_mc_start pulse, mc_done 5 cycles later -> stalls high for 5 cycles, all low in the mc_done cycle, FSM back in RUN; stall_cycles=5.
- Timeout with MC_TIMEOUT=8: mc_done never asserts -> 7 stalled cycles, 1 release cycle, mc_timeout=1 and sticky. rst then clears it.
- Reset mid-MC_BUSY: rst pulse in the 3rd busy cycle -> all outputs 0 immediately, counters 0, FSM in RUN.
